uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver that consumes the 8N1 bit stream produced by the team's transmit stage (`Tx`) and rebuilds the parallel byte. It synchronises the asynchronous line and detects the start bit. It samples each bit at its midpoint, checks the stop bit, and delivers the byte with a one-cycle strobe to the parallel consumer. It sits at the far end of the serial link, directly downstream of `Tx.DataOut`.

## Interface
- `CLKS_PER_BIT`, 32, clocks per bit period; must match the transmitter (`Tx` holds each bit 32 cycles); even, ≥ 4
- `clk` input 1 — single clock; all logic on rising edge
- `reset` input 1 — asynchronous, active-low; one clock, reset asynchronous active-low
- `SerialIn` input 1 — serial line, idle high, asynchronous to `clk`
- `DataOut` output 8 — last correctly received byte; held until next good frame
- `DataOutEn` output 1 — one-cycle strobe: `DataOut` updated this cycle
- `FrameErr` output 1 — one-cycle strobe: stop bit sampled low, byte discarded
- `Busy` output 1 — high while a frame is being received (state ≠ IDLE)

## Operation
- Frame: start bit 0, data bits D0..D7 LSB first, stop bit 1, each `CLKS_PER_BIT` cycles.
- `SerialIn` passes through a 2-flop synchroniser; all decisions use the synchronised value `rx_s`. The synchroniser flops reset to 1.
- States:
  - IDLE: wait for `rx_s`=0. Counter loads `CLKS_PER_BIT/2 - 1`. Go to START.
  - START: count down. At 0, sample `rx_s`. If 1, this is a false start: go to IDLE with no output. If 0, load `CLKS_PER_BIT-1`, clear bit index, go to DATA.
  - DATA: count down. At 0, shift `rx_s` into `shreg[7]` (right shift, so D0 ends in bit 0) and reload the counter. When index = 7 after the shift, go to STOP; otherwise increment index.
  - STOP: count down. At 0, sample `rx_s`.
    - If 1: `DataOut`←`shreg`, pulse `DataOutEn`, go to IDLE.
    - If 0: pulse `FrameErr`, leave `DataOut` unchanged, go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. This prevents a held-low line from re-triggering.
- Counter width is `$clog2(CLKS_PER_BIT)`. The bit index is 3 bits. No wrap occurs beyond the reload values.
- Reset (any time, including mid-frame): state IDLE, counter 0, index 0, `shreg`=0, `DataOut`=0x00, `DataOutEn`=0, `FrameErr`=0, `Busy`=0. The partial frame is lost. A line that is low when reset releases is treated as a start.

## Timing
- t0 is the first rising edge on which IDLE sees `rx_s`=0. This is 2–3 cycles after the line falls.
- Start sample: t0+`CLKS_PER_BIT/2`. Bit k sample: t0+`CLKS_PER_BIT/2`+(k+1)·`CLKS_PER_BIT`. Stop sample: t0+`CLKS_PER_BIT/2`+9·`CLKS_PER_BIT`.
- With the default of 32, the stop sample falls at t0+304.
- `DataOutEn`/`FrameErr` are registered on the stop-sample edge and high for exactly one cycle. They are never high together.
- IDLE is re-entered on the same edge, so a new start bit can be detected on the next cycle. Back-to-back `Tx` frames are accepted with no gap.
- `Busy` rises the cycle after t0 and falls with the result strobe, or on leaving BREAK.
- `DataOut` is stable at all cycles except the strobe edge.

## Structure
- Package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP, BREAK)
  - `UART_CLKS_PER_BIT`=32 default
  - `UART_DATA_BITS`=8
- Sub-module `sync2`: 2-flop synchroniser with asynchronous active-low reset to 1. It is reusable by other async inputs.
- Main FSM, counter, shift register and output registers live in `uart_rx`.

## Test plan
- Reset: assert `reset`=0 mid-idle. Required: `DataOut`=0x00, `DataOutEn`=0, `FrameErr`=0, `Busy`=0.
- Loopback: drive `Tx` with 0xA5 and connect `Tx.DataOut`→`SerialIn`. Required: a single `DataOutEn` pulse with `DataOut`=0xA5 and no `FrameErr`.
- Back-to-back: `Tx` sends 0x00 then 0xFF consecutively. Required: two strobes with 0x00 then 0xFF, exactly 10·32 cycles apart.
- False start: pull `SerialIn` low for 5 cycles only. Required: return to IDLE, no strobe, `DataOut` unchanged.
- Framing error: send 0x3C with the stop bit forced low and the line held low 100 more cycles. Required: `FrameErr` pulse and no `DataOutEn`. `DataOut` keeps its previous value. No new frame starts until the line returns high.
- Mid-frame reset: assert `reset` during bit D4 of 0x55, then release and send 0x81. Required: no output for 0x55, then `DataOut`=0x81 with a `DataOutEn` pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 32;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs; resets to the idle-high level.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling, stop-bit check, one-cycle result strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      SerialIn,
    output logic [UART_DATA_BITS-1:0] DataOut,
    output logic                      DataOutEn,
    output logic                      FrameErr,
    output logic                      Busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_IDX  = 3'(UART_DATA_BITS - 1);

    uart_state_t               state;
    logic [CW-1:0]             cnt;
    logic [2:0]                idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      rx_s;

    sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (SerialIn),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            DataOut   <= '0;
            DataOutEn <= 1'b0;
            FrameErr  <= 1'b0;
        end else begin
            DataOutEn <= 1'b0;
            FrameErr  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        cnt   <= HALF_LOAD;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rx_s) begin
                        state <= IDLE;
                    end else begin
                        cnt   <= FULL_LOAD;
                        idx   <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        // LSB arrives first, so shifting right leaves D0 in bit 0
                        shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
                        cnt   <= FULL_LOAD;
                        if (idx == LAST_IDX)
                            state <= STOP;
                        else
                            idx <= idx + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rx_s) begin
                        DataOut   <= shreg;
                        DataOutEn <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        FrameErr <= 1'b1;
                        state    <= BREAK;
                    end
                end
                BREAK: begin
                    // a line held low must return high before another start is accepted
                    if (rx_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames against an event-level model.
module tb_uart_rx;

    localparam int CPB = 32;
    // negedge-driven line fall -> strobe observed: 3 cycles sync/detect + half bit + 9 full bits
    localparam int LAT = 3 + CPB / 2 + 9 * CPB;

    typedef struct {
        int         cyc;
        bit         ferr;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       SerialIn = 1'b1;
    logic [7:0] DataOut;
    logic       DataOutEn;
    logic       FrameErr;
    logic       Busy;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         both_cnt = 0;
    int         glitch_cnt = 0;
    logic [7:0] held = '0;
    logic [7:0] last_good = '0;
    ev_t        evq[$];
    ev_t        expq[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .SerialIn  (SerialIn),
        .DataOut   (DataOut),
        .DataOutEn (DataOutEn),
        .FrameErr  (FrameErr),
        .Busy      (Busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t e;
        if (DataOutEn || FrameErr) begin
            e.cyc  = cyc;
            e.ferr = FrameErr;
            e.data = DataOut;
            evq.push_back(e);
        end
        if (DataOutEn && FrameErr) both_cnt++;
        if (!reset || DataOutEn) held = DataOut;
        else if (DataOut !== held) glitch_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural transmitter: caller is at a negedge; abort_at>0 cuts the frame short.
    task automatic send(input logic [7:0] b, input bit stop, input int abort_at, output int fall);
        logic [9:0] fr;
        fr   = {stop, b, 1'b0};
        fall = cyc;
        for (int k = 0; k < 10 * CPB; k++) begin
            if (abort_at != 0 && k == abort_at) return;
            SerialIn = fr[k / CPB];
            @(negedge clk);
        end
    endtask

    task automatic add_exp(input int fall, input logic [7:0] b, input bit stop);
        ev_t e;
        e.cyc  = fall + LAT;
        e.ferr = !stop;
        e.data = b;
        expq.push_back(e);
        if (stop) last_good = b;
    endtask

    task automatic check_events(input string tag);
        int n;
        check({tag, "_nev"}, evq.size(), expq.size());
        n = (evq.size() < expq.size()) ? evq.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_ferr"}, 32'(evq[i].ferr), 32'(expq[i].ferr));
            check({tag, "_cyc"}, evq[i].cyc, expq[i].cyc);
            if (!expq[i].ferr) check({tag, "_data"}, evq[i].data, expq[i].data);
        end
        evq.delete();
        expq.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_dout"}, DataOut, 8'h00);
        check({tag, "_en"}, DataOutEn, 1'b0);
        check({tag, "_ferr"}, FrameErr, 1'b0);
        check({tag, "_busy"}, Busy, 1'b0);
    endtask

    initial begin
        int         f;
        int         f2;
        logic [7:0] b;
        bit         stop;

        idle(3);
        check_reset_state("rst0");
        reset = 1'b1;
        idle(20);
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("rst_idle");
        reset = 1'b1;
        last_good = 8'h00;
        idle(10);
        evq.delete();

        send(8'hA5, 1'b1, 0, f);
        add_exp(f, 8'hA5, 1'b1);
        idle(20);
        check_events("lb");
        check("lb_dout", DataOut, last_good);
        check("lb_busy", Busy, 1'b0);

        send(8'h00, 1'b1, 0, f);
        add_exp(f, 8'h00, 1'b1);
        send(8'hFF, 1'b1, 0, f2);
        add_exp(f2, 8'hFF, 1'b1);
        idle(20);
        if (evq.size() >= 2) check("b2b_gap", evq[1].cyc - evq[0].cyc, 10 * CPB);
        check_events("b2b");
        check("b2b_dout", DataOut, last_good);

        SerialIn = 1'b0;
        idle(5);
        check("fs_busy_hi", Busy, 1'b1);
        SerialIn = 1'b1;
        idle(60);
        check_events("fs");
        check("fs_dout", DataOut, last_good);
        check("fs_busy_lo", Busy, 1'b0);

        send(8'h3C, 1'b0, 0, f);
        add_exp(f, 8'h3C, 1'b0);
        idle(100);
        check("fe_break_busy", Busy, 1'b1);
        SerialIn = 1'b1;
        idle(400);
        check_events("fe");
        check("fe_dout", DataOut, last_good);
        check("fe_busy_lo", Busy, 1'b0);

        send(8'h55, 1'b1, 5 * CPB + CPB / 2, f);
        reset = 1'b0;
        SerialIn = 1'b1;
        idle(3);
        check_reset_state("mr");
        reset = 1'b1;
        last_good = 8'h00;
        idle(40);
        send(8'h81, 1'b1, 0, f);
        add_exp(f, 8'h81, 1'b1);
        idle(20);
        check_events("mr");
        check("mr_dout", DataOut, 8'h81);

        for (int i = 0; i < 30; i++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            send(b, stop, 0, f);
            add_exp(f, b, stop);
            if (!stop) begin
                idle($urandom_range(0, 60));
                SerialIn = 1'b1;
                idle($urandom_range(5, 40));
            end else begin
                idle($urandom_range(0, 40));
            end
        end
        idle(20);
        check_events("rnd");
        check("rnd_dout", DataOut, last_good);

        check("both_strobes", both_cnt, 0);
        check("dout_hold", glitch_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
